// File: rtl/rgb_led_pwm_pkg.sv
// Shared constants for the RGB LED PWM driver: channel indices and parameter defaults.
package rgb_led_pwm_pkg;

    // Bit position of each colour inside the select / indicator vectors
    localparam int unsigned CH_R = 2;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 0;

    localparam int unsigned DEF_N_LEDS   = 4;
    localparam int unsigned DEF_COLOR    = 3;
    localparam int unsigned DEF_PWM_BITS = 4;
    localparam int unsigned DEF_PRESCALE = 16;

endpackage

// File: rtl/rgb_led_pwm_if.sv
// Control/LED bundle between the pattern sources and the RGB LED driver.
interface rgb_led_pwm_if
    import rgb_led_pwm_pkg::*;
#(
    parameter int unsigned N_LEDS   = DEF_N_LEDS,
    parameter int unsigned COLOR    = DEF_COLOR,
    parameter int unsigned PWM_BITS = DEF_PWM_BITS
);
    logic [COLOR-1:0]    i_btn;
    logic [N_LEDS-1:0]   i_led;
    logic                i_led_we;
    logic [PWM_BITS-1:0] i_bright;
    logic                i_bright_we;
    logic [COLOR-1:0]    o_led;
    logic [N_LEDS-1:0]   o_led_r;
    logic [N_LEDS-1:0]   o_led_g;
    logic [N_LEDS-1:0]   o_led_b;

    modport master (
        output i_btn, i_led, i_led_we, i_bright, i_bright_we,
        input  o_led, o_led_r, o_led_g, o_led_b
    );

    modport slave (
        input  i_btn, i_led, i_led_we, i_bright, i_bright_we,
        output o_led, o_led_r, o_led_g, o_led_b
    );
endinterface

// File: rtl/rgb_led_pwm_pwm_gen.sv
// Shared PWM timebase (pwm_gen): prescaler producing a tick, and a wrapping PWM counter.
module rgb_led_pwm_pwm_gen
    import rgb_led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                i_rst_n,
    output logic [PWM_BITS-1:0] cnt_o,
    output logic                tick_o
);
    // At least one prescaler bit so PRESCALE=1 still elaborates (always ticks)
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    assign tick_o = (presc_q == PreMax);
    assign cnt_o  = cnt_q;

    // Next-state: prescaler rolls over on tick; PWM counter wraps naturally
    always_comb begin
        presc_d = presc_q + PW'(1);
        cnt_d   = cnt_q;
        if (tick_o) begin
            presc_d = '0;
            cnt_d   = cnt_q + PWM_BITS'(1);
        end
    end

    // Timebase state registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED driver: button-armed channel latches pattern/brightness; shared PWM dims each colour.
module rgb_led_pwm
    import rgb_led_pwm_pkg::*;
#(
    parameter int unsigned N_LEDS   = DEF_N_LEDS,
    parameter int unsigned COLOR    = DEF_COLOR,
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic          clk,
    input  logic          i_rst_n,
    rgb_led_pwm_if.slave  bus
);
    localparam logic [COLOR-1:0] SelRst = COLOR'(1 << CH_R);

    logic [COLOR-1:0]    btn_q, sel_q, sel_d, rise;
    logic [PWM_BITS-1:0] cnt;
    logic                unused_tick;

    rgb_led_pwm_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .cnt_o   (cnt),
        .tick_o  (unused_tick)
    );

    assign rise = bus.i_btn & ~btn_q;

    // Arm the highest newly pressed button; releases leave the selection alone
    always_comb begin
        sel_d = sel_q;
        for (int i = 0; i < int'(COLOR); i++) begin
            if (rise[i]) begin
                sel_d    = '0;
                sel_d[i] = 1'b1;
            end
        end
    end

    // Button edge history and armed-channel register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_q <= '0;
            sel_q <= SelRst;
        end else begin
            btn_q <= bus.i_btn;
            sel_q <= sel_d;
        end
    end

    assign bus.o_led = sel_q;

    for (genvar c = 0; c < int'(COLOR); c++) begin : g_ch
        logic [N_LEDS-1:0]   pattern_q;
        logic [PWM_BITS-1:0] bright_q;
        logic [N_LEDS-1:0]   out_q;
        logic                on;

        // All-ones brightness means fully on rather than 15/16 duty
        assign on = (bright_q == '1) || (cnt < bright_q);

        // Per-channel writes (decoded from the current, pre-update selection) and output stage
        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                pattern_q <= '0;
                bright_q  <= '1;
                out_q     <= '0;
            end else begin
                if (bus.i_led_we && sel_q[c]) begin
                    pattern_q <= bus.i_led;
                end
                if (bus.i_bright_we && sel_q[c]) begin
                    bright_q <= bus.i_bright;
                end
                out_q <= pattern_q & {N_LEDS{on}};
            end
        end
    end

    assign bus.o_led_r = g_ch[CH_R].out_q;
    assign bus.o_led_g = g_ch[CH_G].out_q;
    assign bus.o_led_b = g_ch[CH_B].out_q;
endmodule
